// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the decode-stage front end: opcodes,
// immediate-source encodings, occupancy states and the stored entry layout.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } occ_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  immsrc;
        logic        needsimm;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-source classifier; purely combinational, sits at the
// fetch input so entries are stored already decoded.
module imm_src_decoder
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] immsrc,
    output logic       needsimm,
    output logic       illegal
);

    always_comb begin
        immsrc   = IMM_I;
        needsimm = 1'b1;
        illegal  = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: immsrc = IMM_I;
            OP_STORE:           immsrc = IMM_S;
            OP_BRANCH:          immsrc = IMM_B;
            OP_JAL:             immsrc = IMM_J;
            OP_LUI, OP_AUIPC:   immsrc = IMM_U;
            OP_REG:             needsimm = 1'b0;
            default: begin
                needsimm = 1'b0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// IF/ID register with a 2-entry skid buffer: main entry M drives the ID
// outputs, skid entry S absorbs one instruction while downstream stalls.
module id_stage_ctrl
    import rv32i_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [31:0]     InstrF,
    input  logic [XLEN-1:0] PCF,
    input  logic            ValidF,
    output logic            ReadyD,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            ReadyE,
    output logic            ValidD,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [24:0]     ImmFieldsD,
    output logic [2:0]      ImmSrcD,
    output logic            NeedsImmD,
    output logic            IllegalD
);

    occ_state_t state, state_nxt;
    entry_t     in_p0, m_p1, s_p1;
    logic       vld_m_p1, vld_s_p1;
    logic       vld_m_nxt, vld_s_nxt;
    logic       ready_q;
    logic       accept, consume;
    logic       ld_m_in, ld_m_s, ld_s_in;
    logic [2:0] dec_immsrc;
    logic       dec_needsimm, dec_illegal;

    imm_src_decoder u_dec (
        .opcode   (InstrF[6:0]),
        .immsrc   (dec_immsrc),
        .needsimm (dec_needsimm),
        .illegal  (dec_illegal)
    );

    // Stage p0: fetched instruction, decoded before capture
    always_comb begin
        in_p0.instr    = InstrF;
        in_p0.pc       = PCF;
        in_p0.immsrc   = dec_immsrc;
        in_p0.needsimm = dec_needsimm;
        in_p0.illegal  = dec_illegal;
    end

    assign accept  = ValidF & ready_q;
    assign consume = vld_m_p1 & ReadyE & ~StallD;

    always_comb begin
        state_nxt = state;
        vld_m_nxt = vld_m_p1;
        vld_s_nxt = vld_s_p1;
        ld_m_in   = 1'b0;
        ld_m_s    = 1'b0;
        ld_s_in   = 1'b0;
        if (FlushD) begin
            state_nxt = ST_EMPTY;
            vld_m_nxt = 1'b0;
            vld_s_nxt = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        ld_m_in   = 1'b1;
                        vld_m_nxt = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (consume && accept) begin
                        ld_m_in = 1'b1;
                    end else if (consume) begin
                        vld_m_nxt = 1'b0;
                        state_nxt = ST_EMPTY;
                    end else if (accept) begin
                        ld_s_in   = 1'b1;
                        vld_s_nxt = 1'b1;
                        state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        ld_m_s    = 1'b1;
                        vld_s_nxt = 1'b0;
                        state_nxt = ST_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                    vld_m_nxt = 1'b0;
                    vld_s_nxt = 1'b0;
                end
            endcase
        end
    end

    // Stage p1: main and skid entries
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_EMPTY;
            ready_q     <= 1'b1;
            vld_m_p1    <= 1'b0;
            vld_s_p1    <= 1'b0;
            m_p1.instr    <= RESET_INSTR;
            m_p1.pc       <= '0;
            m_p1.immsrc   <= IMM_I;
            m_p1.needsimm <= 1'b1;
            m_p1.illegal  <= 1'b0;
            s_p1          <= '0;
        end else begin
            state    <= state_nxt;
            ready_q  <= (state_nxt != ST_FULL);
            vld_m_p1 <= vld_m_nxt;
            vld_s_p1 <= vld_s_nxt;
            // Flush presents a NOP with its own decode so the outputs stay coherent
            if (FlushD) begin
                m_p1.instr    <= RESET_INSTR;
                m_p1.immsrc   <= IMM_I;
                m_p1.needsimm <= 1'b1;
                m_p1.illegal  <= 1'b0;
            end else if (ld_m_in) begin
                m_p1 <= in_p0;
            end else if (ld_m_s) begin
                m_p1 <= s_p1;
            end
            if (ld_s_in) begin
                s_p1 <= in_p0;
            end
        end
    end

    assign ReadyD     = ready_q;
    assign ValidD     = vld_m_p1;
    assign InstrD     = m_p1.instr;
    assign PCD        = m_p1.pc;
    assign ImmFieldsD = m_p1.instr[31:7];
    assign ImmSrcD    = m_p1.immsrc;
    assign NeedsImmD  = m_p1.needsimm;
    assign IllegalD   = m_p1.illegal;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: handshake, skid, stall, flush, decode
// and asynchronous reset, with hand-computed expectations.
module tb_id_stage_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        ValidF, StallD, FlushD, ReadyE;
    logic        ReadyD, ValidD, NeedsImmD, IllegalD;
    logic [31:0] InstrD, PCD;
    logic [24:0] ImmFieldsD;
    logic [2:0]  ImmSrcD;

    int total = 0;
    int bad   = 0;

    id_stage_ctrl #(.XLEN(32), .RESET_INSTR(32'h0000_0013)) dut (
        .CLK(CLK), .RST(RST), .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF),
        .ReadyD(ReadyD), .StallD(StallD), .FlushD(FlushD), .ReadyE(ReadyE),
        .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .ImmFieldsD(ImmFieldsD),
        .ImmSrcD(ImmSrcD), .NeedsImmD(NeedsImmD), .IllegalD(IllegalD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then look just after the rising edge
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic re, input logic st, input logic fl);
        @(negedge CLK);
        ValidF = v; InstrF = ins; PCF = pc; ReadyE = re; StallD = st; FlushD = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, {31'd0, ValidD}, 32'd0);
        chk({tag, ".ready"}, {31'd0, ReadyD}, 32'd1);
        chk({tag, ".instr"}, InstrD, 32'h0000_0013);
        chk({tag, ".pc"}, PCD, 32'd0);
        chk({tag, ".immsrc"}, {29'd0, ImmSrcD}, 32'd0);
        chk({tag, ".needsimm"}, {31'd0, NeedsImmD}, 32'd1);
        chk({tag, ".illegal"}, {31'd0, IllegalD}, 32'd0);
    endtask

    logic [31:0] addi_w = 32'hFFC1_0113;
    logic [31:0] seq_i [4] = '{32'h00A1_2223, 32'h0000_0463, 32'h0080_00EF, 32'h1234_50B7};
    logic [2:0]  seq_s [4] = '{3'b001, 3'b010, 3'b011, 3'b100};

    initial begin
        RST = 1'b0; ValidF = 0; InstrF = 0; PCF = 0; StallD = 0; FlushD = 0; ReadyE = 0;
        #12;
        chk_reset("rst");
        @(negedge CLK);
        RST = 1'b1;

        // ADDI with one-cycle latency
        cyc(1, addi_w, 32'h100, 1, 0, 0);
        chk("addi.valid", {31'd0, ValidD}, 32'd1);
        chk("addi.immsrc", {29'd0, ImmSrcD}, 32'd0);
        chk("addi.needsimm", {31'd0, NeedsImmD}, 32'd1);
        chk("addi.fields", {7'd0, ImmFieldsD}, {7'd0, addi_w[31:7]});
        chk("addi.pc", PCD, 32'h100);

        // Back-to-back S/B/J/U
        for (int i = 0; i < 4; i++) begin
            cyc(1, seq_i[i], 32'h104 + 32'(4 * i), 1, 0, 0);
            chk($sformatf("b2b%0d.immsrc", i), {29'd0, ImmSrcD}, {29'd0, seq_s[i]});
            chk($sformatf("b2b%0d.instr", i), InstrD, seq_i[i]);
        end
        cyc(0, 0, 0, 1, 0, 0);
        chk("b2b.drain", {31'd0, ValidD}, 32'd0);

        // Back-pressure: A into M, B into S, C waits
        cyc(1, 32'h0010_0093, 32'h200, 0, 0, 0);
        chk("bp.a.ready", {31'd0, ReadyD}, 32'd1);
        cyc(1, 32'h0020_0113, 32'h204, 0, 0, 0);
        chk("bp.full.ready", {31'd0, ReadyD}, 32'd0);
        chk("bp.full.instr", InstrD, 32'h0010_0093);
        cyc(1, 32'h0030_0193, 32'h208, 0, 0, 0);
        chk("bp.hold.instr", InstrD, 32'h0010_0093);
        chk("bp.hold.ready", {31'd0, ReadyD}, 32'd0);
        cyc(1, 32'h0030_0193, 32'h208, 1, 0, 0);
        chk("bp.b.instr", InstrD, 32'h0020_0113);
        chk("bp.b.pc", PCD, 32'h204);
        chk("bp.b.ready", {31'd0, ReadyD}, 32'd1);
        cyc(1, 32'h0030_0193, 32'h208, 1, 0, 0);
        chk("bp.c.instr", InstrD, 32'h0030_0193);
        chk("bp.c.valid", {31'd0, ValidD}, 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("bp.drain", {31'd0, ValidD}, 32'd0);

        // Flush from FULL drops both entries and the offered instruction
        cyc(1, 32'h0040_0213, 32'h300, 0, 0, 0);
        cyc(1, 32'h0050_0293, 32'h304, 0, 0, 0);
        chk("fl.full", {31'd0, ReadyD}, 32'd0);
        cyc(1, 32'h0060_0313, 32'h308, 0, 0, 1);
        chk("fl.valid", {31'd0, ValidD}, 32'd0);
        chk("fl.ready", {31'd0, ReadyD}, 32'd1);
        chk("fl.instr", InstrD, 32'h0000_0013);
        cyc(0, 0, 0, 1, 0, 0);
        chk("fl.after", {31'd0, ValidD}, 32'd0);

        // Stall for 3 cycles with ReadyE high
        cyc(1, 32'h00A1_2223, 32'h400, 1, 1, 0);
        chk("st.g.instr", InstrD, 32'h00A1_2223);
        cyc(1, 32'h0000_0463, 32'h404, 1, 1, 0);
        chk("st.full.instr", InstrD, 32'h00A1_2223);
        chk("st.full.ready", {31'd0, ReadyD}, 32'd0);
        cyc(1, 32'h0080_00EF, 32'h408, 1, 1, 0);
        chk("st.hold.instr", InstrD, 32'h00A1_2223);
        chk("st.hold.pc", PCD, 32'h400);
        cyc(1, 32'h0080_00EF, 32'h408, 1, 0, 0);
        chk("st.h.instr", InstrD, 32'h0000_0463);
        cyc(1, 32'h0080_00EF, 32'h408, 1, 0, 0);
        chk("st.i.instr", InstrD, 32'h0080_00EF);
        chk("st.i.immsrc", {29'd0, ImmSrcD}, 32'd3);
        cyc(0, 0, 0, 1, 0, 0);
        chk("st.drain", {31'd0, ValidD}, 32'd0);

        // Illegal and register-register decode
        cyc(1, 32'h0000_0007, 32'h500, 1, 0, 0);
        chk("ill.illegal", {31'd0, IllegalD}, 32'd1);
        chk("ill.needsimm", {31'd0, NeedsImmD}, 32'd0);
        chk("ill.immsrc", {29'd0, ImmSrcD}, 32'd0);
        cyc(1, 32'h0020_81B3, 32'h504, 1, 0, 0);
        chk("reg.illegal", {31'd0, IllegalD}, 32'd0);
        chk("reg.needsimm", {31'd0, NeedsImmD}, 32'd0);
        cyc(1, 32'h1234_5197, 32'h508, 1, 0, 0);
        chk("auipc.immsrc", {29'd0, ImmSrcD}, 32'd4);
        chk("auipc.needsimm", {31'd0, NeedsImmD}, 32'd1);

        // Asynchronous reset while FULL
        cyc(1, 32'h0070_0393, 32'h600, 0, 0, 0);
        cyc(1, 32'h0080_0413, 32'h604, 0, 0, 0);
        chk("ar.full", {31'd0, ReadyD}, 32'd0);
        @(negedge CLK);
        ValidF = 0;
        #2;
        RST = 1'b0;
        #1;
        chk_reset("ar");
        @(negedge CLK);
        RST = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
